alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline register feeding the 32-bit ALU (ops ADD,SUB,AND,OR,SLT,SLTU,XOR = 0..6).
//  Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  Selects the A/B operand sources and registers operands, ALUOperation and writeback info.
//  Uses a valid/ready handshake; a flush input kills wrong-path instructions.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register-address width
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      synchronous reset, active-high
//  flush            in   1      kill the held entry and the incoming entry this cycle
//  valid_in         in   1      decode presents an instruction
//  ready_out        out  1      stage accepts an instruction this cycle
//  pc_in            in   XLEN   instruction PC
//  rs1_addr/rs2_addr in  REG_AW source register numbers
//  rs1_data/rs2_data in  XLEN   register-file read data
//  imm_in           in   XLEN   sign-extended immediate
//  src_a_sel        in   2      0=rs1, 1=pc, 2=zero, 3=rs1
//  src_b_sel        in   2      0=rs2, 1=imm, 2=const 4, 3=rs2
//  alu_op_in        in   3      ALU operation code
//  rd_in, reg_write_in in REG_AW,1  destination register and write enable
//  exm_rd, exm_we, exm_data  in REG_AW,1,XLEN  EX/MEM forwarding source
//  wb_rd, wb_we, wb_data     in REG_AW,1,XLEN  MEM/WB forwarding source
//  valid_out        out  1      registered outputs hold a live instruction
//  ready_in         in   1      downstream (ALU/EX) consumes this cycle
//  a, b             out  XLEN   ALU operands (registered)
//  ALUOperation     out  3      registered alu_op_in
//  store_data       out  XLEN   forwarded rs2 value (for stores)
//  rd_out, reg_write_out out REG_AW,1  registered writeback info
// BEHAVIOUR
//  - Reset: valid_out=0, a=b=store_data=0, ALUOperation=0 (ADD), rd_out=0, reg_write_out=0.
//  - ready_out = ~valid_out | ready_in. Combinational, and independent of flush.
//  - Capture when valid_in & ready_out & ~flush: all outputs load at the next edge, valid_out<=1.
//    Latency is 1 cycle.
//  - Consume without capture (ready_in & valid_out & ~(valid_in&ready_out)): valid_out<=0.
//    Data outputs hold their old values.
//  - Stall (valid_out & ~ready_in): every output holds. Forwarding inputs are ignored.
//    Forwarding is sampled only at capture.
//  - flush=1: valid_out<=0 and reg_write_out<=0 next edge. Any valid_in that cycle is dropped.
//    Flush wins over capture and stall.
//  - rst wins over everything, including mid-stall and flush.
//  - Forwarding, per source rsN:
//    - if exm_we & exm_rd==rsN & rsN!=0 -> exm_data
//    - else if wb_we & wb_rd==rsN & rsN!=0 -> wb_data
//    - else rsN_data
//    - EX/MEM has priority over MEM/WB. x0 is never forwarded.
//  - Forwarded rs1/rs2 values feed the src selects. store_data is always the forwarded rs2,
//    regardless of src_b_sel.
//  - When reg_write_in=0 or rd_in=0, reg_write_out is captured as 0.
//  - Upstream must hold its inputs stable while valid_in & ~ready_out.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - ALU op localparams ADD..XOR (3 bits)
//    - SRC_A_{RS1,PC,ZERO} and SRC_B_{RS2,IMM,FOUR} encodings
//  - Sub-module fwd_mux (rs_addr, rs_data, exm_*, wb_* -> fwd_data), instantiated twice.
//  - Everything else is one always block for the register plus combinational selection.
// TESTING
//  1. Reset: assert rst 2 cycles mid-stall with valid_out=1 -> all outputs 0, ready_out=1.
//  2. ADDI: rs1=x5 (data 10), imm=7, src_b=IMM, op=ADD, ready_in=1 -> next cycle a=10, b=7,
//     ALUOperation=0, valid_out=1.
//  3. Forward priority: rs1=x3, exm_rd=3 data 0xAA, wb_rd=3 data 0xBB, both we=1 -> a=0xAA.
//     Repeat with exm_we=0 -> a=0xBB.
//  4. x0: rs2=x0, exm_rd=0, exm_we=1, data 0xFF, rs2_data=0 -> b=0, store_data=0.
//  5. Stall:
//     - ready_in=0 for 3 cycles with new valid_in and changing exm_data -> outputs frozen, ready_out=0.
//     - ready_in=1 -> the next instruction captured one cycle later.
//  6. Flush with valid_in=1 and valid_out=1 -> valid_out=0, reg_write_out=0 next cycle;
//     the dropped instruction never appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand stage: ALU operation codes and operand-source selects.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  // Encoding 3 of either select aliases the register source.
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

endpackage

// File: rtl/fwd_mux.sv
// RAW-hazard bypass for one source register: EX/MEM beats MEM/WB beats the register file.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_we,
  input  logic [XLEN-1:0]   exm_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   fwd_data
);

  logic rs_nonzero;
  logic exm_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a producer that names it must never be bypassed.
  assign rs_nonzero = (rs_addr != '0);
  assign exm_hit    = exm_we && (exm_rd == rs_addr) && rs_nonzero;
  assign wb_hit     = wb_we && (wb_rd == rs_addr) && rs_nonzero;

  always_comb begin
    fwd_data = rs_data;
    if (exm_hit) begin
      fwd_data = exm_data;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register for the ALU: forwards rs1/rs2, selects A/B operands and holds them under
// a valid/ready handshake with flush.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [1:0]        src_a_sel,
  input  logic [1:0]        src_b_sel,
  input  logic [2:0]        alu_op_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_we,
  input  logic [XLEN-1:0]   exm_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [2:0]        ALUOperation,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out
);

  // Handshake: a transfer happens on an edge where valid and ready are both high on that
  // side; ready_out never depends on valid_in or flush, and flush drops both the held
  // entry and whatever valid_in offers in the same cycle.

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] a_sel;
  logic [XLEN-1:0] b_sel;
  logic            capture;
  logic            consume;

  logic              valid_q,      valid_d;
  logic [XLEN-1:0]   a_q,          a_d;
  logic [XLEN-1:0]   b_q,          b_d;
  logic [2:0]        alu_op_q,     alu_op_d;
  logic [XLEN-1:0]   store_data_q, store_data_d;
  logic [REG_AW-1:0] rd_q,         rd_d;
  logic              reg_write_q,  reg_write_d;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr  (rs1_addr),
    .rs_data  (rs1_data),
    .exm_rd   (exm_rd),
    .exm_we   (exm_we),
    .exm_data (exm_data),
    .wb_rd    (wb_rd),
    .wb_we    (wb_we),
    .wb_data  (wb_data),
    .fwd_data (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr  (rs2_addr),
    .rs_data  (rs2_data),
    .exm_rd   (exm_rd),
    .exm_we   (exm_we),
    .exm_data (exm_data),
    .wb_rd    (wb_rd),
    .wb_we    (wb_we),
    .wb_data  (wb_data),
    .fwd_data (rs2_fwd)
  );

  assign ready_out = ~valid_q | ready_in;
  assign capture   = valid_in & ready_out & ~flush;
  assign consume   = valid_q & ready_in;

  always_comb begin
    a_sel = rs1_fwd;
    b_sel = rs2_fwd;
    case (src_a_sel)
      SRC_A_PC:   a_sel = pc_in;
      SRC_A_ZERO: a_sel = '0;
      default:    a_sel = rs1_fwd;
    endcase
    case (src_b_sel)
      SRC_B_IMM:  b_sel = imm_in;
      SRC_B_FOUR: b_sel = XLEN'(32'd4);
      default:    b_sel = rs2_fwd;
    endcase
  end

  always_comb begin
    valid_d      = valid_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_op_d     = alu_op_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (capture) begin
      valid_d      = 1'b1;
      a_d          = a_sel;
      b_d          = b_sel;
      alu_op_d     = alu_op_in;
      store_data_d = rs2_fwd;
      rd_d         = rd_in;
      reg_write_d  = reg_write_in & (rd_in != '0);
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      alu_op_q     <= ALU_ADD;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_op_q     <= alu_op_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign valid_out     = valid_q;
  assign a             = a_q;
  assign b             = b_q;
  assign ALUOperation  = alu_op_q;
  assign store_data    = store_data_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios then random traffic, all
// checked against a transaction-level model and a scoreboard of captured instructions.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] pc_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_in;
  logic [1:0]  src_a_sel;
  logic [1:0]  src_b_sel;
  logic [2:0]  alu_op_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic [4:0]  exm_rd;
  logic        exm_we;
  logic [31:0] exm_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ALUOperation;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;

  int checks = 0;
  int failures = 0;

  // Model: whether an instruction is live, and the bundle {a,b,op,store_data,rd,we} it holds.
  logic         m_valid;
  logic [104:0] m_out;
  logic [104:0] exp_q[$];
  logic [104:0] frozen;
  logic [31:0]  last_exm;

  alu_operand_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .pc_in         (pc_in),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .imm_in        (imm_in),
    .src_a_sel     (src_a_sel),
    .src_b_sel     (src_b_sel),
    .alu_op_in     (alu_op_in),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .exm_rd        (exm_rd),
    .exm_we        (exm_we),
    .exm_data      (exm_data),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .a             (a),
    .b             (b),
    .ALUOperation  (ALUOperation),
    .store_data    (store_data),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [104:0] dut_bundle();
    return {a, b, ALUOperation, store_data, rd_out, reg_write_out};
  endfunction

  // Value an instruction reading register r should see: youngest in-flight writer, else the RF.
  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (exm_we && exm_rd == r) return exm_data;
    if (wb_we && wb_rd == r) return wb_data;
    return rf;
  endfunction

  function automatic logic [104:0] expected_capture();
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] a_opts[4];
    logic [31:0] b_opts[4];
    r1 = reg_value(rs1_addr, rs1_data);
    r2 = reg_value(rs2_addr, rs2_data);
    a_opts = '{r1, pc_in, 32'd0, r1};
    b_opts = '{r2, imm_in, 32'd4, r2};
    return {a_opts[src_a_sel], b_opts[src_b_sel], alu_op_in, r2, rd_in,
            reg_write_in && (rd_in != 5'd0)};
  endfunction

  // One clock: check ready_out and any consumed instruction before the edge, advance the
  // model on the edge, then compare every registered output just after it.
  task automatic tick();
    logic take;
    @(negedge clk);
    take = !m_valid || ready_in;
    chk("ready_out", ready_out, take);
    if (rst) begin
      m_valid = 1'b0;
      m_out   = '0;
      exp_q.delete();
    end else if (flush) begin
      if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid  = 1'b0;
      m_out[0] = 1'b0;
    end else begin
      if (m_valid && ready_in) begin
        chk("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("consumed", dut_bundle(), exp_q.pop_front());
      end
      if (valid_in && take) begin
        m_out   = expected_capture();
        m_valid = 1'b1;
        exp_q.push_back(m_out);
      end else if (m_valid && ready_in) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("valid_out", valid_out, m_valid);
    chk("outputs", dut_bundle(), m_out);
  endtask

  task automatic idle_inputs();
    flush = 0; valid_in = 0; ready_in = 0; pc_in = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; imm_in = 0;
    src_a_sel = 0; src_b_sel = 0; alu_op_in = 0; rd_in = 0; reg_write_in = 0;
    exm_rd = 0; exm_we = 0; exm_data = 0; wb_rd = 0; wb_we = 0; wb_data = 0;
  endtask

  task automatic set_instr(input logic [4:0] r1a, input logic [31:0] r1d,
                           input logic [4:0] r2a, input logic [31:0] r2d,
                           input logic [31:0] imm, input logic [1:0] asel,
                           input logic [1:0] bsel, input logic [2:0] op,
                           input logic [4:0] rd, input logic we);
    rs1_addr = r1a; rs1_data = r1d; rs2_addr = r2a; rs2_data = r2d; imm_in = imm;
    src_a_sel = asel; src_b_sel = bsel; alu_op_in = op; rd_in = rd; reg_write_in = we;
    pc_in = 32'h0000_1000;
  endtask

  task automatic random_inputs();
    rst      = ($urandom_range(0, 49) == 0);
    flush    = ($urandom_range(0, 9) == 0);
    valid_in = ($urandom_range(0, 3) != 0);
    ready_in = ($urandom_range(0, 2) != 0);
    set_instr(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
              $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 6)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    pc_in    = $urandom;
    exm_rd   = 5'($urandom_range(0, 3));
    exm_we   = 1'($urandom_range(0, 1));
    exm_data = $urandom;
    wb_rd    = 5'($urandom_range(0, 3));
    wb_we    = 1'($urandom_range(0, 1));
    wb_data  = $urandom;
  endtask

  initial begin
    m_valid = 1'b0;
    m_out   = '0;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("init_valid", valid_out, 0);
    chk("init_bundle", dut_bundle(), 0);

    // ADDI x8, x5, 7
    set_instr(5'd5, 32'd10, 5'd6, 32'd0, 32'd7, SRC_A_RS1, SRC_B_IMM, ALU_ADD, 5'd8, 1'b1);
    valid_in = 1; ready_in = 1;
    tick();
    valid_in = 0;
    chk("addi_a", a, 32'd10);
    chk("addi_b", b, 32'd7);
    chk("addi_op", ALUOperation, ALU_ADD);
    chk("addi_valid", valid_out, 1);

    // Forwarding priority on rs1=x3
    set_instr(5'd3, 32'h11, 5'd4, 32'h22, 32'd0, SRC_A_RS1, SRC_B_RS2, ALU_XOR, 5'd9, 1'b1);
    exm_rd = 3; exm_we = 1; exm_data = 32'hAA;
    wb_rd = 3; wb_we = 1; wb_data = 32'hBB;
    valid_in = 1;
    tick();
    chk("fwd_exm", a, 32'hAA);
    exm_we = 0;
    tick();
    chk("fwd_wb", a, 32'hBB);
    chk("fwd_rs2_plain", store_data, 32'h22);

    // x0 is never forwarded
    set_instr(5'd1, 32'h5, 5'd0, 32'd0, 32'd0, SRC_A_RS1, SRC_B_RS2, ALU_OR, 5'd0, 1'b1);
    exm_rd = 0; exm_we = 1; exm_data = 32'hFF;
    wb_rd = 0; wb_we = 1; wb_data = 32'hEE;
    tick();
    chk("x0_b", b, 32'd0);
    chk("x0_store", store_data, 32'd0);
    chk("x0_rd_zero_no_we", reg_write_out, 0);

    // Stall with a new instruction waiting and EX/MEM data changing underneath
    set_instr(5'd1, 32'h1234, 5'd2, 32'h5678, 32'd0, SRC_A_RS1, SRC_B_FOUR, ALU_SUB, 5'd7, 1'b1);
    exm_rd = 1; exm_we = 1; wb_we = 0;
    ready_in = 0;
    frozen = dut_bundle();
    for (int i = 0; i < 3; i++) begin
      exm_data = $urandom;
      tick();
      chk("stall_frozen", dut_bundle(), frozen);
      chk("stall_ready", ready_out, 0);
      chk("stall_valid", valid_out, 1);
    end
    last_exm = 32'hC0DE_0001;
    exm_data = last_exm;
    ready_in = 1;
    tick();
    valid_in = 0;
    chk("post_stall_a", a, last_exm);
    chk("post_stall_b", b, 32'd4);
    chk("post_stall_op", ALUOperation, ALU_SUB);

    // Reset mid-stall
    ready_in = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_valid", valid_out, 0);
    chk("rst_bundle", dut_bundle(), 0);
    chk("rst_ready", ready_out, 1);

    // Flush kills the held entry and the incoming one
    set_instr(5'd2, 32'h77, 5'd3, 32'h88, 32'd0, SRC_A_PC, SRC_B_RS2, ALU_AND, 5'd4, 1'b1);
    exm_we = 0;
    valid_in = 1; ready_in = 1;
    tick();
    chk("pre_flush_we", reg_write_out, 1);
    set_instr(5'd6, 32'h99, 5'd7, 32'hAB, 32'd0, SRC_A_RS1, SRC_B_RS2, ALU_SLT, 5'd9, 1'b1);
    flush = 1;
    tick();
    flush = 0; valid_in = 0;
    chk("flush_valid", valid_out, 0);
    chk("flush_we", reg_write_out, 0);
    tick();
    chk("flush_dropped", valid_out, 0);
    chk("flush_dropped_rd", rd_out, 5'd4);

    for (int i = 0; i < 400; i++) begin
      random_inputs();
      tick();
    end

    idle_inputs();
    rst = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
